uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 107 ++++++++++
 tb/tb_uart_tx_buf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Write-addressed byte FIFO feeding an 8N1 UART transmitter.
// Bytes written to UART_ADDR are queued and sent LSB first, one idle-high cycle between frames.
module uart_tx_buf #(
  parameter int          BAUD_DIV  = 434,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] UART_ADDR = 32'h3000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [31:0]            waddr_i,
  input  logic [31:0]            wdata_i,
  output logic                   tx_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   busy_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_reg, state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          addr_hit, wr_accept, pop, baud_done;
  logic          unused_wdata;

  assign unused_wdata = ^wdata_i[31:8];
  assign addr_hit     = we_i && (waddr_i == UART_ADDR);
  assign full_o       = (count_reg == COUNT_FULL);
  assign empty_o      = (count_reg == '0);
  // Fullness is judged before any same-edge pop, so a write to a full FIFO is always dropped.
  assign wr_accept    = addr_hit && !full_o;
  assign baud_done    = (baud_cnt_reg == BAUD_LAST);
  assign count_o      = count_reg;
  assign overflow_o   = overflow_reg;
  assign busy_o       = (state_reg != IDLE) || !empty_o;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    tx_o       = 1'b1;
    case (state_reg)
      IDLE: begin
        if (!empty_o) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        tx_o = shift_reg[0];
        if (baud_done && (bit_idx_reg == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (baud_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
    end else begin
      overflow_reg <= addr_hit && full_o;
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)       rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(wr_accept) - (AW+1)'(pop);
      // The counter restarts on every state entry and at each data-bit boundary.
      if (state_reg == IDLE || baud_done) baud_cnt_reg <= '0;
      else                                baud_cnt_reg <= baud_cnt_reg + BW'(1);
      if (pop)                                bit_idx_reg <= '0;
      else if (state_reg == DATA && baud_done) bit_idx_reg <= bit_idx_reg + 3'd1;
    end
  end

  // Storage and the head-byte read stay reset-free so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) mem[wr_ptr_reg] <= wdata_i[7:0];
    if (pop)                                 shift_reg <= mem[rd_ptr_reg];
    else if (state_reg == DATA && baud_done) shift_reg <= {1'b0, shift_reg[7:1]};
  end
endmodule

// File: tb/tb_uart_tx_buf.sv
// Randomised and directed bench for uart_tx_buf: an occupancy/timing model plus a line decoder
// that compares every received frame against the bytes the model expects to be sent.
module tb_uart_tx_buf;
  localparam int          BAUD_DIV  = 4;
  localparam int          DEPTH     = 16;
  localparam logic [31:0] UART_ADDR = 32'h3000_0000;
  localparam int          FRAME     = 10 * BAUD_DIV;
  localparam int          PERIOD    = FRAME + 1;

  logic        clk = 1'b0;
  logic        rst, we_i;
  logic [31:0] waddr_i, wdata_i;
  logic        tx_o, full_o, empty_o, busy_o, overflow_o;
  logic [4:0]  count_o;

  always #5 clk = ~clk;

  uart_tx_buf #(.BAUD_DIV(BAUD_DIV), .DEPTH(DEPTH), .UART_ADDR(UART_ADDR)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .tx_o(tx_o), .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes held in the FIFO, bytes popped and owed on the line, serializer timing.
  logic [7:0] m_fifo[$];
  logic [7:0] tx_exp[$];
  int  edge_cnt = 0;
  int  ser_free = 0;
  int  last_pop = -1000;
  bit  m_ovf    = 1'b0;
  int  m_accepts = 0;
  int  peak     = 0;

  function automatic bit inflight();
    return (edge_cnt >= last_pop) && (edge_cnt < last_pop + FRAME);
  endfunction

  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
    logic [FRAME-1:0] v;
    logic sym;
    v = '0;
    for (int s = 0; s < 10; s++) begin
      sym = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
      for (int c = 0; c < BAUD_DIV; c++) v[s*BAUD_DIV + c] = sym;
    end
    return v;
  endfunction

  task automatic cycle();
    bit hit, full_pre, do_pop;
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      m_fifo.delete();
      tx_exp.delete();
      m_ovf    = 1'b0;
      ser_free = 0;
      last_pop = -1000;
    end else begin
      hit      = we_i && (waddr_i == UART_ADDR);
      full_pre = (m_fifo.size() == DEPTH);
      do_pop   = (edge_cnt >= ser_free) && (m_fifo.size() > 0);
      m_ovf    = hit && full_pre;
      if (do_pop) begin
        tx_exp.push_back(m_fifo.pop_front());
        last_pop = edge_cnt;
        ser_free = edge_cnt + PERIOD;
      end
      if (hit && !full_pre) begin
        m_fifo.push_back(wdata_i[7:0]);
        m_accepts++;
      end
    end
    #1;
    check("count", count_o, m_fifo.size());
    check("full", full_o, m_fifo.size() == DEPTH);
    check("empty", empty_o, m_fifo.size() == 0);
    check("busy", busy_o, inflight() || (m_fifo.size() > 0));
    check("overflow", overflow_o, m_ovf);
    if (!inflight()) check("tx_idle", tx_o, 1'b1);
    if (int'(count_o) > peak) peak = int'(count_o);
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [7:0] d);
    we_i    = w;
    waddr_i = a;
    wdata_i = {24'($urandom()), d};
    cycle();
    we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Line decoder: a low level starts a frame; collect FRAME samples and compare to the owed byte.
  logic [FRAME-1:0] win;
  int nsamp       = 0;
  bit in_frame    = 1'b0;
  int neg_cyc     = 0;
  int frames_seen = 0;
  int starts[$];

  always @(negedge clk) begin
    logic [7:0] b;
    neg_cyc++;
    if (rst === 1'b1) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx_o === 1'b0) begin
        in_frame = 1'b1;
        win      = '0;
        nsamp    = 1;
        starts.push_back(neg_cyc);
      end
    end else begin
      win[nsamp] = tx_o;
      nsamp++;
      if (nsamp == FRAME) begin
        in_frame = 1'b0;
        frames_seen++;
        check("frame_owed", tx_exp.size() > 0, 1'b1);
        if (tx_exp.size() > 0) begin
          b = tx_exp.pop_front();
          check("frame", win, frame_bits(b));
        end
      end
    end
  end

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (m_fifo.size() == 0 && tx_exp.size() == 0 && !inflight() && !in_frame) break;
      cycle();
    end
    check("drain_done", (m_fifo.size() == 0) && (tx_exp.size() == 0), 1'b1);
  endtask

  logic [7:0] year_str [10] = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h33, 8'h31, 8'h30, 8'h36, 8'h35, 8'h35};

  initial begin
    logic [FRAME-1:0] ev;
    int fs0, acc0, r;
    rst = 1'b1; we_i = 1'b1; waddr_i = UART_ADDR; wdata_i = 32'h0000_00AA;
    // Reset wins over a simultaneous matching write.
    cycle();
    cycle();
    rst = 1'b0; we_i = 1'b0;
    idle(3);

    // Single byte 0x32: exact waveform and busy release.
    drive(1'b1, UART_ADDR, 8'h32);
    check("s1_empty", empty_o, 1'b0);
    ev = frame_bits(8'h32);
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      check("s1_tx", tx_o, ev[i]);
    end
    check("s1_busy_stop", busy_o, 1'b1);
    cycle();
    check("s1_busy_end", busy_o, 1'b0);
    drain(100);

    // Ten back-to-back writes.
    starts.delete();
    peak = 0;
    fs0  = frames_seen;
    for (int i = 0; i < 10; i++) drive(1'b1, UART_ADDR, year_str[i]);
    drain(600);
    check("s2_frames", frames_seen - fs0, 10);
    check("s2_peak", peak, 9);
    for (int i = 1; i < starts.size(); i++) check("s2_period", starts[i] - starts[i-1], PERIOD);

    // Fill to overflow while the first frame is on the line.
    fs0 = frames_seen;
    for (int i = 0; i < 18; i++) drive(1'b1, UART_ADDR, (i == 17) ? 8'hEE : 8'(8'h40 + i));
    check("s3_full", full_o, 1'b1);
    check("s3_count", count_o, 16);
    check("s3_ovf", overflow_o, 1'b1);
    cycle();
    check("s3_ovf_clear", overflow_o, 1'b0);
    drain(900);
    check("s3_frames", frames_seen - fs0, 17);

    // Write to a foreign address.
    drive(1'b1, 32'h0, 8'h55);
    check("s4_count", count_o, 0);
    check("s4_ovf", overflow_o, 1'b0);
    check("s4_tx", tx_o, 1'b1);
    idle(5);

    // Reset during data bit 3 with five bytes queued.
    fs0 = frames_seen;
    drive(1'b1, UART_ADDR, 8'hA5);
    for (int i = 0; i < 5; i++) drive(1'b1, UART_ADDR, 8'(8'h70 + i));
    idle(12);
    check("s5_bit3", tx_o, 1'b0);
    check("s5_queued", count_o, 5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("s5_tx", tx_o, 1'b1);
    check("s5_count", count_o, 0);
    check("s5_busy", busy_o, 1'b0);
    idle(200);
    check("s5_frames", frames_seen - fs0, 0);

    // Random traffic with bursts, foreign addresses and pointer wrap.
    fs0  = frames_seen;
    acc0 = m_accepts;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 199);
      if (r < 9) drive(1'b1, UART_ADDR, 8'($urandom()));
      else if (r < 12) drive(1'b1, UART_ADDR ^ (32'd1 << $urandom_range(0, 31)), 8'($urandom()));
      else if (r == 12) begin
        for (int j = 0; j < 20; j++) drive(1'b1, UART_ADDR, 8'($urandom()));
      end else cycle();
    end
    drain(16 * PERIOD + 100);
    check("s6_frames", frames_seen - fs0, m_accepts - acc0);
    check("s6_wrapped", (m_accepts - acc0) >= 40, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
